magnitude_comparator: RTL and testbench
=======================================

Name:
magnitude_comparator

Overview:
- Registered parameterised magnitude comparator for two SIZE-bit operands A and B.
- Produces one-hot equal / greater / lesser flags, plus max, min and absolute difference.
- All results appear one cycle after a valid input.
- Used as a datapath utility block wherever registered compare results are needed.

Parameters:
- SIZE, 5, operand width in bits (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/signed_mode are sampled on this clock edge.
- signed_mode  input  1  0 = unsigned compare; 1 = two's-complement compare.
- A  input  SIZE  operand A.
- B  input  SIZE  operand B.
- out_valid  output  1  results registered this cycle are fresh.
- aequalsb  output  1  A == B.
- agreaterb  output  1  A > B.
- alesserb  output  1  A < B.
- max_val  output  SIZE  the larger of A and B; A when A == B.
- min_val  output  SIZE  the smaller of A and B; B when A == B.
- abs_diff  output  SIZE  |A - B|, computed as larger minus smaller, modulo 2^SIZE.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - out_valid, aequalsb, agreaterb and alesserb clear to 0.
  - max_val, min_val and abs_diff clear to 0.
  - Reset takes effect immediately. It discards any sample in flight, so no out_valid follows a sample taken before or during reset.
- Latency is 1 cycle. On a rising edge with in_valid = 1:
  - the comparison of that edge's A/B is computed and registered;
  - out_valid = 1 during the following cycle.
- On a rising edge with in_valid = 0:
  - out_valid goes to 0;
  - all result outputs hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no input ready.
- Flag invariant: after any valid sample, exactly one of aequalsb / agreaterb / alesserb is 1. All three are 0 only after reset, before the first valid sample.
- Unsigned mode (signed_mode = 0): operands are treated as 0 .. 2^SIZE-1.
- Signed mode (signed_mode = 1):
  - operands are treated as two's complement, range -2^(SIZE-1) .. 2^(SIZE-1)-1;
  - the MSB is the sign bit;
  - equality is bitwise and identical in both modes.
- max_val and min_val follow the mode's ordering. They output the original bit patterns, with no sign extension.
- abs_diff:
  - always equals max_val - min_val, truncated to SIZE bits;
  - in signed mode it is interpreted as unsigned (e.g. SIZE=5: +15 vs -16 gives 31);
  - no overflow flag exists.
- X/Z on inputs while in_valid = 0 must not disturb any registered output.
- Purely synchronous datapath apart from reset. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle while out_valid = 1 → all outputs 0 immediately, without waiting for a clock edge; after release with in_valid = 0 → outputs stay 0.
- Unsigned, SIZE=5:
  - A=9, B=9, signed_mode=0, in_valid=1 → next cycle out_valid=1, aequalsb=1, agreaterb=0, alesserb=0, max_val=9, min_val=9, abs_diff=0.
  - A=31, B=0 → agreaterb=1, max_val=31, min_val=0, abs_diff=31.
  - A=3, B=20 → alesserb=1, abs_diff=17.
- Signed, SIZE=5:
  - A=5'b11111 (-1), B=5'b00001 (+1), signed_mode=1 → alesserb=1, max_val=5'b00001, min_val=5'b11111, abs_diff=2.
  - Same operands with signed_mode=0 → agreaterb=1, abs_diff=30.
  - A=5'b01111, B=5'b10000, signed_mode=1 → agreaterb=1, abs_diff=31.
- Streaming: 10 consecutive cycles of random A/B with in_valid=1 → out_valid high for 10 cycles, each result matching its input one cycle earlier, flags one-hot every cycle.
- Hold: drop in_valid to 0 and toggle A/B → out_valid=0 and flags/max/min/abs_diff unchanged from the last valid result.

Source files
------------

// File: rtl/magnitude_comparator.sv
// Registered magnitude comparator: one-hot eq/gt/lt flags plus max, min and
// |A-B| for SIZE-bit operands, unsigned or two's-complement, one-cycle latency.
module magnitude_comparator #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            signed_mode,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic            out_valid,
  output logic            aequalsb,
  output logic            agreaterb,
  output logic            alesserb,
  output logic [SIZE-1:0] max_val,
  output logic [SIZE-1:0] min_val,
  output logic [SIZE-1:0] abs_diff
);

  typedef struct packed {
    logic            eq;
    logic            gt;
    logic            lt;
    logic [SIZE-1:0] mx;
    logic [SIZE-1:0] mn;
    logic [SIZE-1:0] df;
  } res_t;

  res_t            res_d, res_q;
  logic            vld_d, vld_q;
  logic [SIZE-1:0] sign_mask, a_key, b_key, mx, mn;

  always_comb begin
    vld_d = in_valid;
    res_d = res_q;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    sign_mask           = '0;
    sign_mask[SIZE-1]   = signed_mode;
    a_key               = A ^ sign_mask;
    b_key               = B ^ sign_mask;
    mx                  = A;
    mn                  = B;
    if (in_valid) begin
      if (a_key < b_key) begin
        mx = B;
        mn = A;
      end
      res_d.eq = (A == B);
      res_d.gt = (a_key > b_key);
      res_d.lt = (a_key < b_key);
      res_d.mx = mx;
      res_d.mn = mn;
      res_d.df = mx - mn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  assign out_valid = vld_q;
  assign aequalsb  = res_q.eq;
  assign agreaterb = res_q.gt;
  assign alesserb  = res_q.lt;
  assign max_val   = res_q.mx;
  assign min_val   = res_q.mn;
  assign abs_diff  = res_q.df;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed-vector bench for magnitude_comparator (SIZE=5): table of hand-computed
// results, plus streaming, hold and asynchronous-reset sequences.
module tb_magnitude_comparator;
  localparam int SIZE = 5;
  localparam int NV   = 14;

  logic            clk, rst_n, in_valid, signed_mode;
  logic [SIZE-1:0] A, B;
  logic            out_valid, aequalsb, agreaterb, alesserb;
  logic [SIZE-1:0] max_val, min_val, abs_diff;

  typedef struct {
    logic            sm;
    logic [SIZE-1:0] a, b;
    logic            eq, gt, lt;
    logic [SIZE-1:0] mx, mn, df;
  } vec_t;

  vec_t tbl [NV];
  int   nvec = 0;
  int   nerr = 0;

  magnitude_comparator #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_mode(signed_mode),
    .A(A), .B(B), .out_valid(out_valid), .aequalsb(aequalsb),
    .agreaterb(agreaterb), .alesserb(alesserb), .max_val(max_val),
    .min_val(min_val), .abs_diff(abs_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sm, input int a, input int b,
                              input logic eq, input logic gt, input logic lt,
                              input int mx, input int mn, input int df);
    vec_t v;
    v.sm = sm; v.a = a[SIZE-1:0]; v.b = b[SIZE-1:0];
    v.eq = eq; v.gt = gt; v.lt = lt;
    v.mx = mx[SIZE-1:0]; v.mn = mn[SIZE-1:0]; v.df = df[SIZE-1:0];
    return v;
  endfunction

  // Reference built from integer arithmetic on the interpreted operand values.
  function automatic vec_t model(input logic sm, input logic [SIZE-1:0] a,
                                 input logic [SIZE-1:0] b);
    vec_t v;
    int   va, vb;
    va = int'(a); vb = int'(b);
    if (sm && a[SIZE-1]) va = va - (1 << SIZE);
    if (sm && b[SIZE-1]) vb = vb - (1 << SIZE);
    v.sm = sm; v.a = a; v.b = b;
    v.eq = (va == vb); v.gt = (va > vb); v.lt = (va < vb);
    v.mx = (va >= vb) ? a : b;
    v.mn = (va >= vb) ? b : a;
    v.df = SIZE'((va >= vb ? va - vb : vb - va));
    return v;
  endfunction

  function automatic logic [3*SIZE+3:0] pack_exp(input logic ov, input vec_t v);
    return {ov, v.eq, v.gt, v.lt, v.mx, v.mn, v.df};
  endfunction

  task automatic check(input string name, input logic [3*SIZE+3:0] exp);
    logic [3*SIZE+3:0] act;
    act = {out_valid, aequalsb, agreaterb, alesserb, max_val, min_val, abs_diff};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got {ov,eq,gt,lt,max,min,diff}=%b,%b%b%b,%0d,%0d,%0d want %b,%b%b%b,%0d,%0d,%0d",
               name, act[3*SIZE+3], act[3*SIZE+2], act[3*SIZE+1], act[3*SIZE],
               act[3*SIZE-1:2*SIZE], act[2*SIZE-1:SIZE], act[SIZE-1:0],
               exp[3*SIZE+3], exp[3*SIZE+2], exp[3*SIZE+1], exp[3*SIZE],
               exp[3*SIZE-1:2*SIZE], exp[2*SIZE-1:SIZE], exp[SIZE-1:0]);
    end
  endtask

  task automatic drive(input logic v, input logic sm, input logic [SIZE-1:0] a,
                       input logic [SIZE-1:0] b);
    in_valid = v; signed_mode = sm; A = a; B = b;
  endtask

  vec_t last, cur, prev;

  initial begin
    //                 sm  a   b  eq gt lt mx  mn  df
    tbl[0]  = mk(1'b0,  9,  9, 1, 0, 0,  9,  9,  0);
    tbl[1]  = mk(1'b0, 31,  0, 0, 1, 0, 31,  0, 31);
    tbl[2]  = mk(1'b0,  3, 20, 0, 0, 1, 20,  3, 17);
    tbl[3]  = mk(1'b1, 31,  1, 0, 0, 1,  1, 31,  2);
    tbl[4]  = mk(1'b0, 31,  1, 0, 1, 0, 31,  1, 30);
    tbl[5]  = mk(1'b1, 15, 16, 0, 1, 0, 15, 16, 31);
    tbl[6]  = mk(1'b1, 16, 15, 0, 0, 1, 15, 16, 31);
    tbl[7]  = mk(1'b1,  0, 31, 0, 1, 0,  0, 31,  1);
    tbl[8]  = mk(1'b1, 16, 16, 1, 0, 0, 16, 16,  0);
    tbl[9]  = mk(1'b0, 31, 30, 0, 1, 0, 31, 30,  1);
    tbl[10] = mk(1'b1, 10,  3, 0, 1, 0, 10,  3,  7);
    tbl[11] = mk(1'b0, 16, 15, 0, 1, 0, 16, 15,  1);
    tbl[12] = mk(1'b1, 20, 25, 0, 0, 1, 25, 20,  5);
    tbl[13] = mk(1'b0,  0,  0, 1, 0, 0,  0,  0,  0);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", '0);
    rst_n = 1'b1;
    @(posedge clk); #1 check("idle_after_reset", '0);

    // Table vectors issued back to back; each checked one edge after issue.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, tbl[i].sm, tbl[i].a, tbl[i].b);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), pack_exp(1'b1, tbl[i]));
    end
    last = tbl[NV-1];

    // Hold: invalid cycles with changing operands must not touch results.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], SIZE'(7 + 9 * i), SIZE'(30 - 5 * i));
      @(posedge clk); #1;
      check($sformatf("hold%0d", i), pack_exp(1'b0, last));
    end

    // Streaming random operands, model-derived expectations.
    for (int i = 0; i < 10; i++) begin
      cur = model(1'($urandom_range(0, 1)), SIZE'($urandom_range(0, 31)),
                  SIZE'($urandom_range(0, 31)));
      drive(1'b1, cur.sm, cur.a, cur.b);
      @(posedge clk); #1;
      check($sformatf("stream%0d", i), pack_exp(1'b1, cur));
      nvec++;
      if (!$onehot({aequalsb, agreaterb, alesserb})) begin
        nerr++;
        $display("FAIL onehot%0d: got flags %b%b%b want exactly one set",
                 i, aequalsb, agreaterb, alesserb);
      end
      prev = cur;
    end

    // Hold after stream with X-free toggling then one more valid sample in flight.
    drive(1'b0, ~prev.sm, ~prev.a, ~prev.b);
    @(posedge clk); #1 check("hold_after_stream", pack_exp(1'b0, prev));

    drive(1'b1, 1'b0, 5'd31, 5'd2);
    @(posedge clk); #1 check("pre_reset_valid", pack_exp(1'b1, model(1'b0, 5'd31, 5'd2)));

    // Mid-cycle async reset while out_valid is high; keep sampling valid inputs.
    drive(1'b1, 1'b0, 5'd4, 5'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", '0);
    @(posedge clk); #1 check("reset_held_with_valid", '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd12, 5'd13);
    rst_n = 1'b1;
    @(posedge clk); #1 check("after_release", '0);
    @(posedge clk); #1 check("after_release2", '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, want finish before 50000");
    $fatal(1);
  end

endmodule
